// File: rtl/dmem_pkg.sv
// dmem_pkg: shared widths, FSM state and range helper
// for the data-memory preload writer.
package dmem_pkg;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 1024;
  localparam int LEN_W  = ADDR_W + 1;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    FLUSH
  } wr_state_e;

  // Extra bits keep a + n from wrapping before the compare.
  function automatic logic fits(
    input logic [ADDR_W-1:0] a,
    input logic [LEN_W-1:0]  n
  );
    logic [ADDR_W+1:0] span;
    span = {2'b00, a} + {1'b0, n};
    return span <= (ADDR_W+2)'(DEPTH);
  endfunction

endpackage

// File: rtl/dmem_preload_writer_if.sv
// dmem_preload_writer_if: host word stream in,
// dmem write port out.
interface dmem_preload_writer_if;
  import dmem_pkg::*;

  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output mem_we,
    output mem_addr,
    output mem_wdata
  );

endinterface

// File: rtl/dmem_wr_addr_gen.sv
// dmem_wr_addr_gen: loadable write-address counter
// with remaining-word count and last flag.
module dmem_wr_addr_gen
  import dmem_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [LEN_W-1:0]  load_len,
  input  logic              step,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  logic [LEN_W-1:0] remaining;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr      <= '0;
      remaining <= '0;
    end else if (load) begin
      addr      <= load_addr;
      remaining <= load_len;
    end else if (step && remaining != '0) begin
      remaining <= remaining - LEN_W'(1);
      // Hold on the final word so the address never wraps past DEPTH-1.
      if (!last)
        addr <= addr + ADDR_W'(1);
    end
  end

  assign last = (remaining == LEN_W'(1));

endmodule

// File: rtl/dmem_preload_writer.sv
// dmem_preload_writer: streams host words into dmem
// while holding the CPU, then reports done and checksum.
module dmem_preload_writer
  import dmem_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(100)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  start_use_base,
  input  logic [ADDR_W-1:0]     start_addr,
  input  logic [LEN_W-1:0]      start_len,
  dmem_preload_writer_if.slave  bus,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  err,
  output logic [DATA_W-1:0]     checksum
);

  wr_state_e         state;
  logic [ADDR_W-1:0] a_sel;
  logic              in_range;
  logic              accept;
  logic              hs;
  logic [ADDR_W-1:0] ag_addr;
  logic              ag_last;

  assign a_sel    = start_use_base ? start_addr : BASE_ADDR;
  assign in_range = fits(a_sel, start_len);
  assign accept   = (state == IDLE) && start && in_range
                  && (start_len != '0);
  assign hs       = bus.in_valid && bus.in_ready;

  dmem_wr_addr_gen u_addr_gen (
    .clk       (clk),
    .reset     (reset),
    .load      (accept),
    .load_addr (a_sel),
    .load_len  (start_len),
    .step      (hs),
    .addr      (ag_addr),
    .last      (ag_last)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      bus.in_ready  <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      cpu_hold      <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      checksum      <= '0;
    end else begin
      bus.mem_we <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            if (!in_range) begin
              err <= 1'b1;
            end else if (start_len == '0) begin
              done     <= 1'b1;
              checksum <= '0;
            end else begin
              checksum     <= '0;
              cpu_hold     <= 1'b1;
              bus.in_ready <= 1'b1;
              state        <= LOAD;
            end
          end
        end
        LOAD: begin
          if (hs) begin
            bus.mem_we    <= 1'b1;
            bus.mem_addr  <= ag_addr;
            bus.mem_wdata <= bus.in_data;
            checksum      <= checksum + bus.in_data;
            // done rides with the final write, seen in FLUSH.
            if (ag_last) begin
              bus.in_ready <= 1'b0;
              done         <= 1'b1;
              state        <= FLUSH;
            end
          end
        end
        FLUSH: begin
          cpu_hold <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_preload_writer.sv
// tb_dmem_preload_writer: directed and random loads
// checked against a queue-based write/checksum model.
module tb_dmem_preload_writer;
  import dmem_pkg::*;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              start_use_base = 1'b0;
  logic [ADDR_W-1:0] start_addr = '0;
  logic [LEN_W-1:0]  start_len = '0;
  logic              cpu_hold;
  logic              done;
  logic              err;
  logic [DATA_W-1:0] checksum;

  dmem_preload_writer_if bus ();

  dmem_preload_writer dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .start_use_base (start_use_base),
    .start_addr     (start_addr),
    .start_len      (start_len),
    .bus            (bus.slave),
    .cpu_hold       (cpu_hold),
    .done           (done),
    .err            (err),
    .checksum       (checksum)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [ADDR_W-1:0] wr_a[$];
  logic [DATA_W-1:0] wr_d[$];
  int done_cnt = 0;
  int err_cnt  = 0;
  int run      = 0;
  int run_max  = 0;

  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      wr_a.push_back(bus.mem_addr);
      wr_d.push_back(bus.mem_wdata);
      run++;
      if (run > run_max) run_max = run;
    end else begin
      run = 0;
    end
    if (done === 1'b1) done_cnt++;
    if (err === 1'b1) err_cnt++;
  end

  logic [DATA_W-1:0] stim[$];
  logic [DATA_W-1:0] exp_ck = '0;

  task automatic clear_log();
    wr_a.delete();
    wr_d.delete();
    done_cnt = 0;
    err_cnt  = 0;
    run_max  = 0;
  endtask

  task automatic pulse_start(input bit ub, input int sa, input int len);
    @(posedge clk); #1;
    start          = 1'b1;
    start_use_base = ub;
    start_addr     = ADDR_W'(sa);
    start_len      = LEN_W'(len);
    @(posedge clk); #1;
    start      = 1'b0;
    start_addr = ADDR_W'($urandom);
    start_len  = LEN_W'($urandom_range(0, 2047));
  endtask

  // gap: 0 = valid held high, 1 = toggle 1,0,1,0, 2 = random
  task automatic do_req(
    input bit ub, input int sa, input int len,
    input int gap, input bit poke
  );
    int a;
    int idx;
    int cyc;
    bit hold_ok;
    logic [DATA_W-1:0] s;
    a = ub ? sa : 100;
    clear_log();
    pulse_start(ub, sa, len);
    if (a + len > DEPTH || len == 0) begin
      @(negedge clk);
      chk("err_pulse", err, (a + len > DEPTH));
      chk("done_pulse", done, !(a + len > DEPTH));
      chk("hold_idle", cpu_hold, 0);
      if (!(a + len > DEPTH)) exp_ck = '0;
      chk("cksum_idle", checksum, exp_ck);
      @(negedge clk);
      chk("pulse_once", {done, err}, 0);
      chk("no_write", wr_a.size(), 0);
      return;
    end
    idx = 0;
    cyc = 0;
    hold_ok = 1'b1;
    while (idx < len && cyc < 8 * len + 16) begin
      case (gap)
        0: bus.in_valid = 1'b1;
        1: bus.in_valid = (cyc % 2 == 0);
        default: bus.in_valid = 1'($urandom_range(0, 1));
      endcase
      bus.in_data = stim[idx];
      if (poke && cyc == 1) begin
        start     = 1'b1;
        start_len = '0;
      end
      @(negedge clk);
      if (cpu_hold !== 1'b1) hold_ok = 1'b0;
      if (bus.in_valid && bus.in_ready === 1'b1) idx++;
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
    end
    bus.in_valid = 1'b0;
    chk("hs_count", idx, len);
    chk("hold_load", hold_ok, 1);
    @(negedge clk);
    chk("last_we", bus.mem_we, 1);
    chk("last_done", done, 1);
    chk("last_addr", bus.mem_addr, a + len - 1);
    chk("last_hold", cpu_hold, 1);
    chk("ready_drop", bus.in_ready, 0);
    @(negedge clk);
    chk("hold_rel", cpu_hold, 0);
    chk("done_1cyc", done, 0);
    chk("we_idle", bus.mem_we, 0);
    chk("addr_hold", bus.mem_addr, a + len - 1);
    s = '0;
    for (int i = 0; i < len; i++) s += stim[i];
    exp_ck = s;
    chk("checksum", checksum, exp_ck);
    chk("wr_count", wr_a.size(), len);
    for (int i = 0; i < len && i < wr_a.size(); i++) begin
      chk("wr_addr", wr_a[i], a + i);
      chk("wr_data", wr_d[i], stim[i]);
    end
    chk("done_cnt", done_cnt, 1);
    chk("err_cnt", err_cnt, 0);
    if (gap == 0) chk("we_run", run_max, len);
    if (gap == 1) chk("we_run", run_max, 1);
  endtask

  task automatic set_stim(input int n);
    stim.delete();
    for (int i = 0; i < n; i++) stim.push_back($urandom);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"}, bus.in_ready, 0);
    chk({tag, "_we"}, bus.mem_we, 0);
    chk({tag, "_addr"}, bus.mem_addr, 0);
    chk({tag, "_wdata"}, bus.mem_wdata, 0);
    chk({tag, "_hold"}, cpu_hold, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_cksum"}, checksum, 0);
  endtask

  initial begin
    int idx;
    int cyc;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    #1 reset = 1'b0;
    #1 chk_all_zero("rst");
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    stim = '{32'd9, 32'd3, 32'd7, 32'd1, 32'd8,
             32'd2, 32'd6, 32'd0, 32'd5, 32'd4};
    do_req(0, 0, 10, 0, 0);
    chk("t1_sum45", checksum, 45);
    do_req(0, 0, 10, 1, 0);
    chk("t2_sum45", checksum, 45);

    set_stim(5);
    do_req(1, 1020, 5, 0, 0);
    chk("t3_err_cnt", err_cnt, 1);
    do_req(1, 1020, 4, 0, 0);

    do_req(0, 0, 0, 0, 0);
    chk("t4_zero_ck", checksum, 0);
    set_stim(8);
    do_req(1, 300, 8, 0, 1);

    // Reset in the middle of a 10-word load after 3 writes.
    set_stim(10);
    clear_log();
    pulse_start(0, 0, 10);
    idx = 0;
    cyc = 0;
    bus.in_valid = 1'b1;
    while (idx < 3 && cyc < 40) begin
      bus.in_data = stim[idx];
      @(negedge clk);
      if (bus.in_ready === 1'b1) idx++;
      @(posedge clk); #1;
      cyc++;
    end
    chk("t5_hs", idx, 3);
    bus.in_data = stim[3];
    @(negedge clk);
    #2 reset = 1'b0;
    #1 chk_all_zero("t5_async");
    repeat (2) @(negedge clk);
    bus.in_valid = 1'b0;
    chk("t5_wr_cnt", wr_a.size(), 3);
    for (int i = 0; i < 3 && i < wr_a.size(); i++) begin
      chk("t5_wr_addr", wr_a[i], 100 + i);
      chk("t5_wr_data", wr_d[i], stim[i]);
    end
    @(posedge clk); #1 reset = 1'b1;
    exp_ck = '0;
    set_stim(10);
    do_req(0, 0, 10, 2, 0);

    stim = '{32'hFFFF_FFFF, 32'h0000_0002};
    do_req(1, 500, 2, 0, 0);
    chk("t6_wrap", checksum, 32'h0000_0001);

    for (int k = 0; k < 10; k++) begin
      int ub;
      int sa;
      int len;
      ub  = $urandom_range(0, 1);
      sa  = (k % 3 == 0) ? $urandom_range(1000, 1023)
                         : $urandom_range(0, 1023);
      len = $urandom_range(0, 24);
      set_stim(len + 1);
      do_req(ub[0], sa, len, $urandom_range(0, 2), k[0]);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
